input_reader: RTL
=================

INPUT_READER -- requirements
Module: input_reader

Interface
REQ-001 SHALL have parameters: DATA_BITS, 512, stream width (64-byte beat); MAX_REQ_BYTES, 4096, max bytes per host read request (power of 2, ≥64); MAX_OUTSTANDING, 4, max in-flight read requests (power of 2).
REQ-002 SHALL have ports (name  direction  width  meaning): clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have: buf_valid in 1, buf_ready out 1, buf_vaddr in VADDR_BITS, buf_size in 28; host buffer descriptor (buffer_t layout).
REQ-004 SHALL have: req_valid out 1, req_ready in 1, req_vaddr out VADDR_BITS, req_len out 28; host read request.
REQ-005 SHALL have: rd_valid in 1, rd_ready out 1, rd_data in DATA_BITS; host read data, in request order.
REQ-006 SHALL have: out_valid out 1, out_ready in 1, out_data out DATA_BITS, out_keep out DATA_BITS/8, out_last out 1; output stream.
REQ-007 SHALL have: busy out 1 (descriptor active); done out 1 (one-cycle pulse per completed buffer); err out 1 (sticky misalignment flag).

Function
REQ-008 SHALL implement states IDLE, ISSUE, DRAIN; buf_ready=1 only in IDLE.
REQ-009 IDLE, buf handshake, buf_size=0: SHALL stay IDLE, no requests/beats, pulse done next cycle.
REQ-010 IDLE, buf handshake, buf_vaddr[5:0]≠0: SHALL set err, drop descriptor, stay IDLE, no done pulse.
REQ-011 IDLE, buf handshake, aligned, size>0: SHALL latch vaddr/size, total_beats=ceil(size/64), go ISSUE next cycle.
REQ-012 ISSUE: chunk=min(remaining, MAX_REQ_BYTES − (cur_vaddr mod MAX_REQ_BYTES)); request never crosses a MAX_REQ_BYTES boundary.
REQ-013 req_valid SHALL assert in ISSUE only while in-flight requests < MAX_OUTSTANDING; req_vaddr/req_len stable until req_ready.
REQ-014 On req handshake: cur_vaddr+=chunk, remaining−=chunk, push ceil(chunk/64) to internal beat-count FIFO (depth MAX_OUTSTANDING); remaining=0 → DRAIN.
REQ-015 In-flight count SHALL decrement when received beats of head request reach its pushed count (FIFO pop); simultaneous push+pop leaves count unchanged.
REQ-016 Data path combinational: out_valid=rd_valid∧busy, rd_ready=out_ready∧busy, out_data=rd_data; zero latency; rd_ready=0 in IDLE.
REQ-017 out_keep SHALL be all-ones except final beat: low (size mod 64) bits set, all-ones if size mod 64=0.
REQ-018 out_last SHALL be 1 exactly on beat total_beats; its handshake SHALL pulse done next cycle and return to IDLE.
REQ-019 Beats may arrive in ISSUE (overlapping issue); final beat cannot precede final request handshake.
REQ-020 Beat counter 28-bit; no wrap for buf_size ≤ 2**28−1.

Reset
REQ-021 rst SHALL force IDLE, clear counters, beat FIFO, err; req_valid, out_valid, out_last, done, busy =0; buf_ready=1 from first cycle after reset.
REQ-022 Reset mid-buffer SHALL abandon descriptor; host-side read channel is reset together; late data undefined.

Configuration
REQ-023 INPUT_READER_STATS_EN defined: SHALL add outputs stat_bytes (64-bit, += popcount(out_keep) per out handshake) and stat_buffers (32-bit, +1 per done), saturating, cleared by rst.
REQ-024 INPUT_READER_STATS_EN undefined: stats ports and logic SHALL be absent; remaining behaviour identical.

Verification
REQ-025 vaddr=0x1000, size=256, ready always → one req (0x1000,256), 4 beats, keep all-ones, last on beat 4, done one cycle later.
REQ-026 vaddr=0x0FC0, size=200 → reqs (0x0FC0,64),(0x1000,136); 4 beats; final keep=0x00FF; last on beat 4.
REQ-027 size=20480, aligned at 0x0, rd_valid held 0 → exactly 4 reqs of 4096 then req_valid stays 0; after 64 beats 5th req issues.
REQ-028 vaddr=0x1004 → err=1, buf_ready stays 1, no req, no done; err held until rst.
REQ-029 Random out_ready backpressure, size=1000 → 16 beats, data order preserved, final keep low 40 bits set, stat_bytes=1000 when STATS_EN.
REQ-030 rst asserted mid-DRAIN after 2 of 8 beats → next cycle IDLE, outputs zero, new descriptor processed correctly.

Source files
------------

// File: rtl/input_reader.sv
// -----------------------------------------------------------------------------
// input_reader
//
// Turns a host buffer descriptor (virtual address + byte size) into a series
// of host read requests, then forwards the returned read data as an output
// stream with byte keeps and an end-of-buffer marker.
//
// Read requests never cross a MAX_REQ_BYTES boundary. At most MAX_OUTSTANDING
// requests are in flight at once. A small FIFO holds the beat count of each
// in-flight request; an entry is retired when all of its beats have arrived.
//
// Parameters
//   DATA_BITS        stream width (512 = one 64-byte beat)
//   MAX_REQ_BYTES    largest host read request, power of two, >= 64
//   MAX_OUTSTANDING  largest number of in-flight requests, power of two
//   VADDR_BITS       host virtual address width
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   buf_valid/buf_ready/buf_vaddr/buf_size   descriptor input
//   req_valid/req_ready/req_vaddr/req_len    host read request
//   rd_valid/rd_ready/rd_data                host read data (request order)
//   out_valid/out_ready/out_data/out_keep/out_last   output stream
//   busy   a descriptor is being processed
//   done   one-cycle pulse per completed buffer
//   err    sticky flag, set by a misaligned descriptor
//
// Optional feature (macro INPUT_READER_STATS_EN)
//   stat_bytes    64-bit saturating count of streamed bytes
//   stat_buffers  32-bit saturating count of completed buffers
// -----------------------------------------------------------------------------
module input_reader #(
    parameter int DATA_BITS       = 512,
    parameter int MAX_REQ_BYTES   = 4096,
    parameter int MAX_OUTSTANDING = 4,
    parameter int VADDR_BITS      = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   buf_valid,
    output logic                   buf_ready,
    input  logic [VADDR_BITS-1:0]  buf_vaddr,
    input  logic [27:0]            buf_size,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [VADDR_BITS-1:0]  req_vaddr,
    output logic [27:0]            req_len,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic [DATA_BITS-1:0]   rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_BITS-1:0]   out_data,
    output logic [DATA_BITS/8-1:0] out_keep,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
`ifdef INPUT_READER_STATS_EN
    ,
    output logic [63:0]            stat_bytes,
    output logic [31:0]            stat_buffers
`endif
);

    localparam int BEAT_BYTES = DATA_BITS / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int OFF_BITS   = $clog2(MAX_REQ_BYTES);
    localparam int CNT_BITS   = OFF_BITS - BEAT_SHIFT + 1;
    localparam int PTR_BITS   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OCC_BITS   = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state, state_next;
    logic [VADDR_BITS-1:0] cur_vaddr;
    logic [27:0]           remaining;
    logic [27:0]           total_beats;
    logic [27:0]           beat_cnt;
    logic [BEAT_SHIFT-1:0] tail_bytes;
    logic [CNT_BITS-1:0]   fifo_mem [MAX_OUTSTANDING];
    logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
    logic [OCC_BITS-1:0]   fifo_count;
    logic [CNT_BITS-1:0]   head_rcvd;
    logic                  done_r, err_r;

    logic                  buf_fire, buf_misaligned, buf_start;
    logic                  req_fire, rd_fire, last_beat, head_done, pop;
    logic [27:0]           space, chunk;
    logic [CNT_BITS-1:0]   chunk_beats;
    logic [BEAT_BYTES-1:0] keep_tail;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_BITS'(1);
    endfunction

    assign buf_fire       = buf_valid && buf_ready;
    assign buf_misaligned = buf_vaddr[BEAT_SHIFT-1:0] != '0;
    assign buf_start      = buf_fire && !buf_misaligned && (buf_size != 28'd0);

    // Bytes left before the next MAX_REQ_BYTES boundary bound the request size.
    assign space       = 28'(MAX_REQ_BYTES) - 28'(cur_vaddr[OFF_BITS-1:0]);
    assign chunk       = (remaining < space) ? remaining : space;
    assign chunk_beats = CNT_BITS'((chunk + 28'(BEAT_BYTES - 1)) >> BEAT_SHIFT);

    assign req_vaddr = cur_vaddr;
    assign req_len   = chunk;
    assign req_fire  = req_valid && req_ready;

    // Data path is pure wiring; the reader only gates it with busy.
    assign out_valid = rd_valid && busy;
    assign rd_ready  = out_ready && busy;
    assign out_data  = rd_data;
    assign rd_fire   = rd_valid && rd_ready;

    assign last_beat = (beat_cnt + 28'd1) == total_beats;
    assign out_last  = out_valid && last_beat;
    assign out_keep  = last_beat ? keep_tail : '1;

    assign head_done = (head_rcvd + CNT_BITS'(1)) == fifo_mem[rd_ptr];
    assign pop       = rd_fire && (fifo_count != '0) && head_done;

    assign done = done_r;
    assign err  = err_r;

    // A tail of zero bytes means the last beat is completely full.
    always_comb begin
        keep_tail = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            keep_tail[i] = (tail_bytes == '0) || (i < int'(tail_bytes));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        buf_ready  = (state == IDLE);
        busy       = (state != IDLE);
        req_valid  = (state == ISSUE) && (fifo_count < OCC_BITS'(MAX_OUTSTANDING));
        case (state)
            IDLE:    if (buf_start) state_next = ISSUE;
            ISSUE:   if (req_fire && (chunk == remaining)) state_next = DRAIN;
            DRAIN:   state_next = DRAIN;
            default: state_next = IDLE;
        endcase
        if (rd_fire && last_beat) state_next = IDLE;
    end

    // The beat-count storage needs no reset; occupancy is tracked by pointers.
    always_ff @(posedge clk) begin
        if (req_fire) fifo_mem[wr_ptr] <= chunk_beats;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_vaddr   <= '0;
            remaining   <= '0;
            total_beats <= '0;
            beat_cnt    <= '0;
            tail_bytes  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            head_rcvd   <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (buf_fire) begin
                if (buf_misaligned) begin
                    err_r <= 1'b1;
                end else if (buf_size == 28'd0) begin
                    done_r <= 1'b1;
                end else begin
                    cur_vaddr   <= buf_vaddr;
                    remaining   <= buf_size;
                    total_beats <= 28'(({1'b0, buf_size} + 29'(BEAT_BYTES - 1)) >> BEAT_SHIFT);
                    tail_bytes  <= buf_size[BEAT_SHIFT-1:0];
                    beat_cnt    <= '0;
                end
            end
            if (req_fire) begin
                cur_vaddr <= cur_vaddr + VADDR_BITS'(chunk);
                remaining <= remaining - chunk;
                wr_ptr    <= ptr_inc(wr_ptr);
            end
            if (rd_fire) begin
                beat_cnt <= beat_cnt + 28'd1;
                if (last_beat) done_r <= 1'b1;
                if (fifo_count != '0) begin
                    if (head_done) begin
                        head_rcvd <= '0;
                        rd_ptr    <= ptr_inc(rd_ptr);
                    end else begin
                        head_rcvd <= head_rcvd + CNT_BITS'(1);
                    end
                end
            end
            case ({req_fire, pop})
                2'b10:   fifo_count <= fifo_count + OCC_BITS'(1);
                2'b01:   fifo_count <= fifo_count - OCC_BITS'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef INPUT_READER_STATS_EN
    logic [64:0] bytes_sum;
    assign bytes_sum = {1'b0, stat_bytes} + 65'($countones(out_keep));

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bytes   <= '0;
            stat_buffers <= '0;
        end else begin
            if (rd_fire) stat_bytes <= bytes_sum[64] ? '1 : bytes_sum[63:0];
            if (done_r && (stat_buffers != '1)) stat_buffers <= stat_buffers + 32'd1;
        end
    end
`endif

endmodule
